key_press_filter: RTL and testbench
===================================

# key_press_filter

Debounces one synchronized push-button level and turns it into clean single-cycle events for the game FSM. Sits directly downstream of a `Synchronizer` instance, one instance per player key. Emits press and release pulses, a debounced level, a long-press pulse, and a wrapping press counter.

## Interface

Parameters:
- `DEBOUNCE_CYCLES`, default 1000: consecutive samples needed to accept a level change; legal range ≥ 3.
- `LONG_CYCLES`, default 25_000_000: cycles after an accepted press before `long_press` fires; 0 disables.
- `IN_ACTIVE_LOW`, default 1: 1 means `in_sync` = 0 is "pressed" (DE1 KEYs).

Ports:
- `clk`  in  1  system clock; single clock domain.
- `reset`  in  1  asynchronous, active-low reset; asserted when 0.
- `in_sync`  in  1  synchronized raw key level, taken from the `Synchronizer` `out` port.
- `pressed`  out  1  debounced level; 1 while the key is considered down.
- `press`  out  1  one-cycle pulse when a press is accepted.
- `release`  out  1  one-cycle pulse when a release is accepted.
- `long_press`  out  1  one-cycle pulse, at most once per press.
- `press_count`  out  8  number of accepted presses, modulo 256.

## Operation

- Internal level `lvl` = `in_sync` XOR `IN_ACTIVE_LOW`, so 1 means pressed. `lvl` is sampled on every rising `clk` edge.
- Debounce counter is `$clog2(DEBOUNCE_CYCLES)` bits wide.
- Hold counter is `$clog2(LONG_CYCLES+1)` bits wide, with a minimum of 1.
- State machine `IDLE`, `PRESS_WAIT`, `HELD`, `RELEASE_WAIT`:
  - `IDLE`: `lvl`=1 → `PRESS_WAIT`, cnt←1. Otherwise stay.
  - `PRESS_WAIT`:
    - `lvl`=0 → `IDLE`; glitch rejected, no output.
    - `lvl`=1 and cnt==DEBOUNCE_CYCLES-1 → `HELD`, `press`←1, `press_count`←`press_count`+1 (8-bit wrap, 255→0), hold←0.
    - Otherwise cnt←cnt+1.
  - `HELD`: `lvl`=0 → `RELEASE_WAIT`, cnt←1. Otherwise stay.
  - `RELEASE_WAIT`:
    - `lvl`=1 → `HELD`; hold counter not cleared.
    - `lvl`=0 and cnt==DEBOUNCE_CYCLES-1 → `IDLE`, `release`←1.
    - Otherwise cnt←cnt+1.
- `pressed` = 1 exactly in `HELD` and `RELEASE_WAIT`. Registered from state, not from `lvl`.
- Hold counter:
  - Increments on each edge while in `HELD` or `RELEASE_WAIT`.
  - Saturates at `LONG_CYCLES`.
  - On the edge where it first becomes `LONG_CYCLES`, `long_press`←1 for one cycle.
  - Never fires again until the next accepted press. Never fires when `LONG_CYCLES`=0.
- `press`, `release` and `long_press` are registered pulses, high for exactly one cycle. They are deasserted on every other edge.
- Simultaneous events: `release` and `long_press` may both be asserted on the same edge. Both are reported.
- Reset (`reset`=0, any time):
  - State → `IDLE`; all counters → 0.
  - `pressed`, `press`, `release`, `long_press` → 0; `press_count` → 0.
  - A press in progress is dropped without a `release` pulse.
- Post-reset artifact: the upstream synchronizer resets `out` low. With `IN_ACTIVE_LOW`=1 this reads as pressed for up to 2 edges after reset release. `DEBOUNCE_CYCLES` ≥ 3 rejects it. A key genuinely held through reset produces `press` once the debounce completes.

## Timing

- Press latency: `lvl`=1 on `DEBOUNCE_CYCLES` consecutive edges k … k+D-1.
  - `press` and `pressed` go high after edge k+D-1.
  - `press_count` updates on that same edge.
- Release latency: symmetric. `lvl`=0 on D consecutive edges; `release` high and `pressed` low after the last of them.
- `long_press` goes high `LONG_CYCLES` edges after the edge that raised `press`, if the key is still down.
- Any opposing sample during a wait state aborts that wait on the same edge. The counter restarts from 1 on the next qualifying sample.
- No combinational path from `in_sync` to any output.

## Test plan

Common setup unless noted: D = `DEBOUNCE_CYCLES` = 4, `LONG_CYCLES` = 10, `IN_ACTIVE_LOW` = 1.

- Clean press/release: `in_sync` 1→0 held 20 cycles, then 0→1.
  - `press` 1 cycle after the 4th low sample; `pressed` high; `press_count`=1.
  - `long_press` 10 cycles after `press`.
  - `release` after the 4th high sample; `pressed` low.
- Bounce rejection: `in_sync` low for 3 cycles, high 1, low 3, high.
  - No `press`; `pressed` stays 0; `press_count`=0.
- Release bounce: while pressed, `in_sync` high 2 cycles then low again.
  - No `release`; `pressed` stays 1.
  - `long_press` still fires exactly once, 10 cycles after `press`.
- Counter wrap: 256 clean presses.
  - `press_count` reads 255 after the 255th and 0 after the 256th.
  - Exactly 256 `press` pulses.
- Reset mid-press: assert `reset`=0 while `pressed`=1.
  - All outputs 0 immediately (asynchronous); no `release` pulse.
  - After release with `in_sync`=1: state `IDLE`.
  - With `in_sync` held 0 through reset: `press` 4 edges after reset release.
- Power-up artifact: upstream synchronizer output low for 2 cycles after reset, then high.
  - No `press` or `pressed`.

Source files
------------

// File: rtl/key_press_filter.sv
// Debounces one synchronized key level into a clean level plus press/release,
// long-press pulses and a wrapping 8-bit press counter. All outputs are registered.
module key_press_filter #(
  parameter int DEBOUNCE_CYCLES = 1000,
  parameter int LONG_CYCLES     = 25_000_000,
  parameter bit IN_ACTIVE_LOW   = 1'b1
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       in_sync,
  output logic       pressed,
  output logic       press,
  output logic       release_o,
  output logic       long_press,
  output logic [7:0] press_count
);

  localparam int CW     = $clog2(DEBOUNCE_CYCLES);
  localparam int HW_RAW = $clog2(LONG_CYCLES + 1);
  localparam int HW     = (HW_RAW < 1) ? 1 : HW_RAW;

  localparam logic [CW-1:0] CNT_ONE  = CW'(1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(LONG_CYCLES);
  localparam bit            LONG_EN  = (LONG_CYCLES > 0);

  typedef enum logic [1:0] {
    IDLE,
    PRESS_WAIT,
    HELD,
    RELEASE_WAIT
  } state_e;

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [HW-1:0]   hold_q, hold_d;
  logic [7:0]      count_q, count_d;
  logic            pressed_q, pressed_d;
  logic            press_q, press_d;
  logic            release_q, release_d;
  logic            long_q, long_d;
  logic            lvl;

  // lvl is 1 whenever the key is physically down, whatever the board polarity.
  assign lvl = in_sync ^ IN_ACTIVE_LOW;

  always_comb begin
    // NOTE: every combinational output gets a default first so no path leaves it
    // unassigned; without these, synthesis would infer latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    hold_d    = hold_q;
    count_d   = count_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    long_d    = 1'b0;

    // Hold counter runs while the key counts as down; it stops at HOLD_MAX, so the
    // long-press pulse can only fire once per accepted press.
    if ((state_q == HELD || state_q == RELEASE_WAIT) && hold_q != HOLD_MAX) begin
      hold_d = hold_q + 1'b1;
      long_d = LONG_EN && (hold_d == HOLD_MAX);
    end

    case (state_q)
      IDLE: begin
        if (lvl) begin
          state_d = PRESS_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      PRESS_WAIT: begin
        if (!lvl) begin
          state_d = IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = HELD;
          press_d = 1'b1;
          count_d = count_q + 1'b1;
          hold_d  = '0;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      HELD: begin
        if (!lvl) begin
          state_d = RELEASE_WAIT;
          cnt_d   = CNT_ONE;
        end
      end
      RELEASE_WAIT: begin
        if (lvl) begin
          state_d = HELD;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = IDLE;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    pressed_d = (state_d == HELD) || (state_d == RELEASE_WAIT);
  end

  // NOTE: state registers use non-blocking assignments so every flop samples the
  // pre-edge values; the reset clears all of them asynchronously.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      hold_q    <= '0;
      count_q   <= '0;
      pressed_q <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
      long_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      hold_q    <= hold_d;
      count_q   <= count_d;
      pressed_q <= pressed_d;
      press_q   <= press_d;
      release_q <= release_d;
      long_q    <= long_d;
    end
  end

  assign pressed     = pressed_q;
  assign press       = press_q;
  assign release_o   = release_q;
  assign long_press  = long_q;
  assign press_count = count_q;

endmodule

// File: tb/tb_key_press_filter.sv
// Directed bench for key_press_filter with D=4, LONG=10, active-low input:
// a vector table for the single-cycle behaviour plus hand sequences for wrap and reset.
module tb_key_press_filter;

  logic       clk = 1'b0;
  logic       reset;
  logic       in_sync;
  logic       pressed, press, release_o, long_press;
  logic [7:0] press_count;

  key_press_filter #(
    .DEBOUNCE_CYCLES(4),
    .LONG_CYCLES    (10),
    .IN_ACTIVE_LOW  (1'b1)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .in_sync    (in_sync),
    .pressed    (pressed),
    .press      (press),
    .release_o  (release_o),
    .long_press (long_press),
    .press_count(press_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        in_v;
    logic [11:0] exp;  // {pressed, press, release, long_press, press_count}
  } vec_t;

  vec_t vecs[$];
  int   n_vec = 0;
  int   n_err = 0;
  int   n_press = 0, n_release = 0, n_long = 0, n_pressed_cyc = 0;

  function automatic logic [11:0] outs();
    return {pressed, press, release_o, long_press, press_count};
  endfunction

  task automatic check(input string name, input logic [11:0] act, input logic [11:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic add(input int n, input logic v, input logic p, input logic pr,
                     input logic rl, input logic lg, input logic [7:0] c);
    vec_t e;
    e.in_v = v;
    e.exp  = {p, pr, rl, lg, c};
    for (int i = 0; i < n; i++) vecs.push_back(e);
  endtask

  // Drives one input sample, lets one rising edge take it, then samples outputs.
  task automatic tick(input logic v);
    in_sync = v;
    @(posedge clk);
    #1;
    if (press)      n_press++;
    if (release_o)  n_release++;
    if (long_press) n_long++;
    if (pressed)    n_pressed_cyc++;
  endtask

  task automatic do_reset(input logic v);
    in_sync = v;
    reset   = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  initial begin
    int s_press, s_release, s_long, s_pcyc, lat;

    // Clean press, long press at +10, clean release (in_sync=0 is pressed).
    add(3, 0, 0, 0, 0, 0, 8'd0);
    add(1, 0, 1, 1, 0, 0, 8'd1);
    add(9, 0, 1, 0, 0, 0, 8'd1);
    add(1, 0, 1, 0, 0, 1, 8'd1);
    add(6, 0, 1, 0, 0, 0, 8'd1);
    add(3, 1, 1, 0, 0, 0, 8'd1);
    add(1, 1, 0, 0, 1, 0, 8'd1);
    add(2, 1, 0, 0, 0, 0, 8'd1);
    // Press bounce: 3 low, 1 high, 3 low, high -> rejected.
    add(3, 0, 0, 0, 0, 0, 8'd1);
    add(1, 1, 0, 0, 0, 0, 8'd1);
    add(3, 0, 0, 0, 0, 0, 8'd1);
    add(2, 1, 0, 0, 0, 0, 8'd1);
    // Release bounce inside the hold window; long press still once at +10.
    add(3, 0, 0, 0, 0, 0, 8'd1);
    add(1, 0, 1, 1, 0, 0, 8'd2);
    add(2, 0, 1, 0, 0, 0, 8'd2);
    add(2, 1, 1, 0, 0, 0, 8'd2);
    add(5, 0, 1, 0, 0, 0, 8'd2);
    add(1, 0, 1, 0, 0, 1, 8'd2);
    add(3, 0, 1, 0, 0, 0, 8'd2);
    add(3, 1, 1, 0, 0, 0, 8'd2);
    add(1, 1, 0, 0, 1, 0, 8'd2);
    // Release and long press completing on the same edge.
    add(3, 0, 0, 0, 0, 0, 8'd2);
    add(1, 0, 1, 1, 0, 0, 8'd3);
    add(6, 0, 1, 0, 0, 0, 8'd3);
    add(3, 1, 1, 0, 0, 0, 8'd3);
    add(1, 1, 0, 0, 1, 1, 8'd3);
    add(1, 1, 0, 0, 0, 0, 8'd3);

    in_sync = 1'b1;
    reset   = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_state", outs(), 12'h000);
    reset = 1'b1;

    foreach (vecs[i]) begin
      tick(vecs[i].in_v);
      check($sformatf("vec[%0d]", i), outs(), vecs[i].exp);
    end

    // 256 clean presses from reset: count reads 255 then wraps to 0.
    do_reset(1'b1);
    s_press = n_press;
    s_long  = n_long;
    for (int i = 1; i <= 256; i++) begin
      repeat (4) tick(1'b0);
      if (i == 255) check("count_255", {4'h0, press_count}, 12'd255);
      if (i == 256) check("count_wrap", {4'h0, press_count}, 12'd0);
      repeat (4) tick(1'b1);
    end
    check("wrap_press_pulses", 12'(n_press - s_press), 12'd256);
    check("wrap_no_long", 12'(n_long - s_long), 12'd0);

    // Reset mid-press with the key held through reset.
    do_reset(1'b1);
    repeat (4) tick(1'b0);
    check("pre_reset_pressed", outs(), 12'hC01);
    s_release = n_release;
    #2;
    reset = 1'b0;
    #1;
    check("async_reset_outs", outs(), 12'h000);
    repeat (2) tick(1'b0);
    check("held_in_reset_outs", outs(), 12'h000);
    reset = 1'b1;
    lat = 0;
    for (int k = 1; k <= 20; k++) begin
      tick(1'b0);
      if (press) begin
        lat = k;
        break;
      end
    end
    check("held_reset_press_latency", 12'(lat), 12'd4);
    check("held_reset_count", {4'h0, press_count}, 12'd1);
    check("no_release_on_reset", 12'(n_release - s_release), 12'd0);
    repeat (4) tick(1'b1);

    // Reset mid-press, key released before reset ends: back to idle, silent.
    repeat (4) tick(1'b0);
    #2;
    reset   = 1'b0;
    in_sync = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b1;
    s_press = n_press; s_release = n_release; s_pcyc = n_pressed_cyc;
    repeat (8) tick(1'b1);
    check("idle_after_reset_press", 12'(n_press - s_press), 12'd0);
    check("idle_after_reset_release", 12'(n_release - s_release), 12'd0);
    check("idle_after_reset_pressed", 12'(n_pressed_cyc - s_pcyc), 12'd0);

    // Power-up artifact: synchronizer low for 2 edges after reset, then high.
    do_reset(1'b0);
    s_press = n_press; s_pcyc = n_pressed_cyc;
    repeat (2) tick(1'b0);
    repeat (8) tick(1'b1);
    check("powerup_no_press", 12'(n_press - s_press), 12'd0);
    check("powerup_no_pressed", 12'(n_pressed_cyc - s_pcyc), 12'd0);
    check("powerup_outs", outs(), 12'h000);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
